// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_buffer_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 4;
    localparam int INSTR_BYTES   = 4;

endpackage

// File: rtl/fetch_buffer_if.sv
// Icache request/response, redirect and decode handshake bundle for fetch_buffer.
interface fetch_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            icache_req;
    logic [XLEN-1:0] icache_adr;
    logic            icache_gnt;
    logic            icache_rvalid;
    logic [31:0]     icache_rdata;
    logic            redirect_v;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [CW-1:0]   occupancy;

    modport master (
        output icache_req, icache_adr, dec_valid, dec_instr, dec_pc, occupancy,
        input  icache_gnt, icache_rvalid, icache_rdata, redirect_v, redirect_pc, dec_ready
    );

    modport slave (
        input  icache_req, icache_adr, dec_valid, dec_instr, dec_pc, occupancy,
        output icache_gnt, icache_rvalid, icache_rdata, redirect_v, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_buffer_fifo_sync.sv
// Generic synchronous FIFO with flush; head is read straight from the entry array.
module fifo_sync #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  T                             data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output T                             head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && !flush_i && (cnt_q != CW'(DEPTH));
    assign do_pop  = pop_i  && !flush_i && (cnt_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage carries no reset; validity comes from the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_buffer.sv
// Decoupled fetch front end: credit-limited icache requests, in-order response
// queue to decode, and stale-response discard after a redirect.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] reset_adr_i,
    fetch_buffer_if.master  fb_io
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    logic [XLEN-1:0] pc_q, pc_d, rpc_q, rpc_d;
    logic [CW-1:0]   out_q, out_d, drop_q, drop_d;
    logic            run_q;
    logic [CW-1:0]   occ;
    logic [CW:0]     credit_used;
    logic            full, empty;
    logic            req, grant, resp, push, pop;
    fetch_entry_t    head, push_data;

    always_comb begin
        credit_used = {1'b0, out_q} + {1'b0, occ};
        req   = run_q && !fb_io.redirect_v && (credit_used < (CW+1)'(DEPTH));
        grant = req && fb_io.icache_gnt;
        // A response with nothing outstanding belongs to a request from before reset.
        resp  = fb_io.icache_rvalid && (out_q != '0);
        push  = resp && (drop_q == '0) && !fb_io.redirect_v;
        pop   = !empty && fb_io.dec_ready && !fb_io.redirect_v;
        push_data = '{pc: rpc_q, instr: fb_io.icache_rdata};

        pc_d   = pc_q;
        rpc_d  = rpc_q;
        out_d  = out_q;
        drop_d = drop_q;
        if (fb_io.redirect_v) begin
            pc_d   = fb_io.redirect_pc & ALIGN_MASK;
            rpc_d  = fb_io.redirect_pc & ALIGN_MASK;
            out_d  = out_q - CW'(resp);
            drop_d = out_q - CW'(resp);
        end else begin
            if (grant) begin
                pc_d = pc_q + XLEN'(INSTR_BYTES);
            end
            if (push) begin
                rpc_d = rpc_q + XLEN'(INSTR_BYTES);
            end
            if (resp && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            out_d = out_q + CW'(grant) - CW'(resp);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= reset_adr_i & ALIGN_MASK;
            rpc_q  <= reset_adr_i & ALIGN_MASK;
            out_q  <= '0;
            drop_q <= '0;
            run_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            rpc_q  <= rpc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
            run_q  <= 1'b1;
        end
    end

    fifo_sync #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .flush_i (fb_io.redirect_v),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occ),
        .head_o  (head)
    );

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && full));
            assert (out_q <= CW'(DEPTH));
        end
    end

    assign fb_io.icache_req = req;
    assign fb_io.icache_adr = pc_q;
    assign fb_io.dec_valid  = !empty;
    assign fb_io.dec_instr  = empty ? '0 : head.instr;
    assign fb_io.dec_pc     = empty ? '0 : head.pc;
    assign fb_io.occupancy  = occ;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: icache model plus a request/queue scoreboard.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] reset_adr = 32'h8000_0000;

    fetch_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fb ();

    fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reset_adr_i (reset_adr),
        .fb_io       (fb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        bit          stale;
        int          gcyc;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t pend[$];
    ent_t mq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int npops = 0;
    int ngrants = 0;
    int ndrops = 0;
    logic [31:0] fpc;
    logic [31:0] last_pop_pc = 32'h0;
    bit saw_wrap = 1'b0;

    logic        s_req, s_valid;
    logic [31:0] s_adr, s_pc, s_instr;
    logic [2:0]  s_occ;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input bit g, input bit allow_rv, input bit redir,
                        input logic [31:0] rpc, input bit rdy);
        bit   rv, exp_req, do_pop;
        req_t r;
        ent_t e;
        @(negedge clk);
        cyc++;
        rv = allow_rv && (pend.size() != 0) && (pend[0].gcyc < cyc);
        fb.icache_gnt    = g;
        fb.icache_rvalid = rv;
        fb.icache_rdata  = rv ? mem_word(pend[0].adr) : $urandom;
        fb.redirect_v    = redir;
        fb.redirect_pc   = rpc;
        fb.dec_ready     = rdy;
        #1;
        s_req = fb.icache_req; s_adr = fb.icache_adr; s_valid = fb.dec_valid;
        s_pc = fb.dec_pc; s_instr = fb.dec_instr; s_occ = fb.occupancy;

        exp_req = !redir && ((pend.size() + mq.size()) < DEPTH);
        total++;
        if (s_req !== exp_req) begin
            bad++; $display("FAIL req cyc=%0d got=%b exp=%b", cyc, s_req, exp_req);
        end
        total++;
        if (s_adr !== fpc) begin
            bad++; $display("FAIL adr cyc=%0d got=%h exp=%h", cyc, s_adr, fpc);
        end
        total++;
        if (int'(s_occ) != mq.size()) begin
            bad++; $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, s_occ, mq.size());
        end
        total++;
        if (s_valid !== (mq.size() != 0)) begin
            bad++; $display("FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, s_valid, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            total++;
            if (s_pc !== mq[0].pc || s_instr !== mq[0].instr) begin
                bad++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, s_pc, s_instr, mq[0].pc, mq[0].instr);
            end
        end

        do_pop = !redir && rdy && (mq.size() != 0);
        if (do_pop) begin
            e = mq.pop_front();
            npops++;
            if (last_pop_pc == 32'hFFFF_FFFC && e.pc == 32'h0) saw_wrap = 1'b1;
            last_pop_pc = e.pc;
            $display("pop cyc=%0d pc=%h instr=%h", cyc, e.pc, e.instr);
        end
        if (rv) begin
            r = pend.pop_front();
            if (redir || r.stale) ndrops++;
            else mq.push_back('{pc: r.adr, instr: mem_word(r.adr)});
        end
        if (redir) begin
            mq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            fpc = rpc & ~32'h3;
        end else if (exp_req && g) begin
            pend.push_back('{adr: fpc, stale: 1'b0, gcyc: cyc});
            fpc += INSTR_BYTES;
            ngrants++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (pend.size() != 0 || mq.size() != 0); i++)
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        total++;
        if (pend.size() != 0 || mq.size() != 0) begin
            bad++; $display("FAIL drain pending=%0d queued=%0d exp=0", pend.size(), mq.size());
        end
    endtask

    task automatic test_reset();
        fb.icache_gnt = 1'b0; fb.icache_rvalid = 1'b0; fb.icache_rdata = '0;
        fb.redirect_v = 1'b0; fb.redirect_pc = '0; fb.dec_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (fb.icache_req !== 1'b0 || fb.dec_valid !== 1'b0 || fb.occupancy !== 3'd0) begin
            bad++; $display("FAIL reset_ctl got req=%b valid=%b occ=%0d exp 0/0/0",
                            fb.icache_req, fb.dec_valid, fb.occupancy);
        end
        total++;
        if (fb.icache_adr !== 32'h8000_0000 || fb.dec_pc !== 32'h0 || fb.dec_instr !== 32'h0) begin
            bad++; $display("FAIL reset_data got adr=%h pc=%h instr=%h exp 80000000/0/0",
                            fb.icache_adr, fb.dec_pc, fb.dec_instr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        fpc = 32'h8000_0000;
    endtask

    task automatic test_streaming();
        int p0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        p0 = npops;
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        total++;
        if (npops - p0 != 15) begin
            bad++; $display("FAIL stream_rate got=%0d exp=15", npops - p0);
        end
    endtask

    task automatic test_backpressure();
        int g0;
        drain();
        g0 = ngrants;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        total++;
        if (ngrants - g0 > DEPTH || s_occ !== 3'd4 || s_req !== 1'b0) begin
            bad++; $display("FAIL backpressure got grants=%0d occ=%0d req=%b exp <=4/4/0",
                            ngrants - g0, s_occ, s_req);
        end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_redirect_inflight();
        int p0, d0;
        drain();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        d0 = ndrops;
        p0 = npops;
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 12 && npops == p0; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        total++;
        if (npops == p0 || last_pop_pc !== 32'h100 || ndrops - d0 != 2) begin
            bad++; $display("FAIL redirect_first got pc=%h drops=%0d exp pc=00000100 drops=2",
                            last_pop_pc, ndrops - d0);
        end
    endtask

    task automatic test_redirect_coincident();
        int d0;
        drain();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        d0 = ndrops;
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        total++;
        if (s_occ !== 3'd0 || s_valid !== 1'b0) begin
            bad++; $display("FAIL coincident_flush got occ=%0d valid=%b exp 0/0", s_occ, s_valid);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        total++;
        if (ndrops - d0 != 2) begin
            bad++; $display("FAIL coincident_drops got=%0d exp=2", ndrops - d0);
        end
    endtask

    task automatic test_grant_stall();
        logic [31:0] a0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        a0 = s_adr;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            total++;
            if (s_adr !== a0) begin
                bad++; $display("FAIL stall_adr got=%h exp=%h", s_adr, a0);
            end
        end
        step(1'b0, 1'b1, 1'b1, 32'h202, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        total++;
        if (s_adr !== 32'h200) begin
            bad++; $display("FAIL redirect_align got=%h exp=00000200", s_adr);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        total++;
        if (saw_wrap !== 1'b1) begin
            bad++; $display("FAIL pc_wrap got=%b exp=1", saw_wrap);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        reset_adr = 32'h0000_4000;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (fb.dec_valid !== 1'b0 || fb.icache_req !== 1'b0 || fb.occupancy !== 3'd0) begin
            bad++; $display("FAIL async_reset got valid=%b req=%b occ=%0d exp 0/0/0",
                            fb.dec_valid, fb.icache_req, fb.occupancy);
        end
        pend.delete();
        mq.delete();
        fpc = 32'h0000_4000;
        @(negedge clk);
        reset_n = 1'b1;
        // Stray response from a pre-reset request while nothing is outstanding.
        @(negedge clk);
        fb.icache_gnt = 1'b0; fb.icache_rvalid = 1'b1; fb.icache_rdata = 32'hDEAD_BEEF;
        fb.redirect_v = 1'b0; fb.dec_ready = 1'b1;
        #1;
        total++;
        if (fb.icache_req !== 1'b1 || fb.icache_adr !== 32'h0000_4000) begin
            bad++; $display("FAIL first_req got req=%b adr=%h exp 1/00004000",
                            fb.icache_req, fb.icache_adr);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0);
        drain();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_grant_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
